// File: rtl/flash_sample_reader.sv
// Streams 16-bit audio samples from 32-bit flash words, two samples per word, forward or reverse.
// Optional macro PAUSE_MUTE_EN: audio_out reads zero while play is low.
module flash_sample_reader #(
    parameter logic [22:0] START_ADDR = 23'h000000,
    parameter logic [22:0] END_ADDR   = 23'h07FFFF
) (
    input  logic        CLK_50M,
    input  logic        reset,
    input  logic        play,
    input  logic        reverse,
    input  logic        sample_tick,
    input  logic        restart,
    output logic        flash_mem_read,
    output logic [22:0] flash_mem_address,
    input  logic        flash_mem_waitrequest,
    input  logic [31:0] flash_mem_readdata,
    input  logic        flash_mem_readdatavalid,
    output logic [15:0] audio_out,
    output logic        audio_valid,
    output logic        tick_missed
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, WAIT_TICK} state_t;

    state_t      state_q;
    logic [22:0] addr_q;
    logic        dir_q;
    logic        restart_pend_q;
    logic        read_q;
    logic [31:0] word_q;
    logic [15:0] sample_q;
    logic        valid_q;
    logic        missed_q;

    logic [22:0] addr_step_d;
    logic [22:0] restart_addr_d;
    logic        tick_go_d;

    always_comb begin
        addr_step_d    = addr_q;
        restart_addr_d = reverse ? END_ADDR : START_ADDR;
        tick_go_d      = sample_tick && play;
        if (dir_q) begin
            addr_step_d = (addr_q == START_ADDR) ? END_ADDR : addr_q - 23'd1;
        end else begin
            addr_step_d = (addr_q == END_ADDR) ? START_ADDR : addr_q + 23'd1;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= START_ADDR;
            dir_q          <= 1'b0;
            restart_pend_q <= 1'b0;
            read_q         <= 1'b0;
            word_q         <= 32'h0;
            sample_q       <= 16'h0000;
            valid_q        <= 1'b0;
            missed_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (restart) begin
                        addr_q <= restart_addr_d;
                    end else if (tick_go_d) begin
                        read_q  <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    // A tick that coincides with restart resolves as restart and is not a miss.
                    if (sample_tick && !restart) begin
                        missed_q <= 1'b1;
                    end
                    if (restart) begin
                        restart_pend_q <= 1'b1;
                    end
                    if (!flash_mem_waitrequest) begin
                        read_q  <= 1'b0;
                        state_q <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (sample_tick && !restart) begin
                        missed_q <= 1'b1;
                    end
                    if (flash_mem_readdatavalid) begin
                        if (restart_pend_q || restart) begin
                            restart_pend_q <= 1'b0;
                            addr_q         <= restart_addr_d;
                            state_q        <= IDLE;
                        end else begin
                            word_q   <= flash_mem_readdata;
                            dir_q    <= reverse;
                            sample_q <= reverse ? flash_mem_readdata[31:16]
                                                : flash_mem_readdata[15:0];
                            valid_q  <= 1'b1;
                            state_q  <= WAIT_TICK;
                        end
                    end else if (restart) begin
                        restart_pend_q <= 1'b1;
                    end
                end
                WAIT_TICK: begin
                    if (restart) begin
                        addr_q  <= restart_addr_d;
                        state_q <= IDLE;
                    end else if (tick_go_d) begin
                        // Second half of the word follows the direction latched at capture.
                        sample_q <= dir_q ? word_q[15:0] : word_q[31:16];
                        valid_q  <= 1'b1;
                        addr_q   <= addr_step_d;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign flash_mem_read    = read_q;
    assign flash_mem_address = addr_q;
    assign audio_valid       = valid_q;
    assign tick_missed       = missed_q;

`ifdef PAUSE_MUTE_EN
    assign audio_out = play ? sample_q : 16'h0000;
`else
    assign audio_out = sample_q;
`endif

endmodule

// File: tb/tb_flash_sample_reader.sv
// Self-checking bench for flash_sample_reader: directed scenarios followed by randomized operations
// checked against a transaction-level model of sample order and address progression.
module tb_flash_sample_reader;

    localparam int START_I = 0;
    localparam int END_I   = 'h7FFFF;
    localparam logic [22:0] START_A = 23'(START_I);
    localparam logic [22:0] END_A   = 23'(END_I);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic        reverse = 1'b0;
    logic        sample_tick = 1'b0;
    logic        restart = 1'b0;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic        flash_mem_waitrequest = 1'b0;
    logic [31:0] flash_mem_readdata = 32'h0;
    logic        flash_mem_readdatavalid = 1'b0;
    logic [15:0] audio_out;
    logic        audio_valid;
    logic        tick_missed;

    flash_sample_reader dut (
        .CLK_50M                 (clk),
        .reset                   (reset),
        .play                    (play),
        .reverse                 (reverse),
        .sample_tick             (sample_tick),
        .restart                 (restart),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .audio_out               (audio_out),
        .audio_valid             (audio_valid),
        .tick_missed             (tick_missed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Flash contents; two addresses carry the words used by the directed scenarios.
    function automatic logic [31:0] mem_word(input logic [22:0] a);
        if (a == 23'h000000) return 32'h1234ABCD;
        if (a == 23'h07FFFF) return 32'h11112222;
        return {a[15:0] ^ 16'hC3A5, a[15:0] * 16'd7 + 16'h0101};
    endfunction

    // Slave: stall a configurable number of cycles, then return data 1..3 cycles after acceptance.
    int          stall_cfg = 0;
    int          stall_cnt = 0;
    int          lat_cnt = 0;
    bit          in_req = 1'b0;
    bit          accepting = 1'b0;
    logic [22:0] acc_addr = '0;
    int          n_accepts = 0;

    always @(negedge clk) begin
        flash_mem_readdatavalid = 1'b0;
        if (lat_cnt != 0) begin
            lat_cnt = lat_cnt - 1;
            if (lat_cnt == 0) begin
                flash_mem_readdatavalid = 1'b1;
                flash_mem_readdata      = mem_word(acc_addr);
            end
        end
        if (accepting) begin
            lat_cnt   = int'($urandom_range(1, 3));
            accepting = 1'b0;
        end
        if (flash_mem_read) begin
            if (!in_req) begin
                in_req    = 1'b1;
                stall_cnt = stall_cfg;
            end
            if (stall_cnt > 0) begin
                flash_mem_waitrequest = 1'b1;
                stall_cnt = stall_cnt - 1;
            end else begin
                flash_mem_waitrequest = 1'b0;
                accepting = 1'b1;
                in_req    = 1'b0;
                acc_addr  = flash_mem_address;
                n_accepts = n_accepts + 1;
            end
        end else begin
            in_req = 1'b0;
            flash_mem_waitrequest = 1'($urandom_range(0, 1));
        end
    end

    int valid_cnt = 0;
    always @(posedge clk) begin
        if (audio_valid) valid_cnt <= valid_cnt + 1;
    end

    // Reference model state
    logic [22:0] m_addr = START_A;
    bit          m_missed = 1'b0;
    int          m_valids = 0;
    int          m_reads = 0;

    function automatic logic [22:0] next_addr(input logic [22:0] a, input bit rev);
        int n;
        int i;
        n = END_I - START_I + 1;
        i = int'(a) - START_I;
        i = rev ? (i + n - 1) % n : (i + 1) % n;
        return 23'(START_I + i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    // One word: fetch, first sample, optional pause, then second sample or a restart in WAIT_TICK.
    task automatic do_word(input bit rev, input int stall, input bit miss, input bit pause, input bit tail_restart);
        logic [31:0] w;
        logic [15:0] first;
        logic [15:0] second;
        int          rd_cycles;
        bit          got;
        bit          bad;
        bit          nr;
        w      = mem_word(m_addr);
        first  = rev ? w[31:16] : w[15:0];
        second = rev ? w[15:0] : w[31:16];
        reverse   = rev;
        stall_cfg = stall;
        play = 1'b0;
        pulse_tick();
        chk("idle_pause_no_read", 32'(flash_mem_read), 32'd0);
        play = 1'b1;
        pulse_tick();
        chk("req_read", 32'(flash_mem_read), 32'd1);
        chk("req_addr", 32'(flash_mem_address), 32'(m_addr));
        m_reads++;
        rd_cycles = 0;
        got = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (audio_valid) begin
                got = 1'b1;
                break;
            end
            if (flash_mem_read) begin
                rd_cycles++;
                if (flash_mem_address !== m_addr) bad = 1'b1;
            end
            if (miss && c == 0) begin
                sample_tick = 1'b1;
                m_missed = 1'b1;
            end
            step();
            sample_tick = 1'b0;
        end
        chk("first_valid_seen", 32'(got), 32'd1);
        chk("read_addr_stable", 32'(bad), 32'd0);
        chk("read_cycles", 32'(rd_cycles), 32'(stall + 1));
        chk("first_sample", 32'(audio_out), 32'(first));
        m_valids++;
        // Direction changes now must not affect the word already captured.
        nr = 1'($urandom_range(0, 1));
        reverse = nr;
        step();
        chk("valid_one_cycle", 32'(audio_valid), 32'd0);
        if (pause) begin
            play = 1'b0;
            bad = 1'b0;
            for (int k = 0; k < 10; k++) begin
                pulse_tick();
                if (audio_valid || flash_mem_read) bad = 1'b1;
                step();
                if (audio_valid || flash_mem_read) bad = 1'b1;
            end
            chk("pause_quiet", 32'(bad), 32'd0);
`ifdef PAUSE_MUTE_EN
            chk("pause_out", 32'(audio_out), 32'h0);
`else
            chk("pause_out", 32'(audio_out), 32'(first));
`endif
            play = 1'b1;
            #1;
            chk("resume_out", 32'(audio_out), 32'(first));
        end
        if (tail_restart) begin
            restart = 1'b1;
            sample_tick = 1'b1;
            step();
            restart = 1'b0;
            sample_tick = 1'b0;
            chk("restart_wt_no_valid", 32'(audio_valid), 32'd0);
            m_addr = nr ? END_A : START_A;
        end else begin
            pulse_tick();
            chk("second_valid", 32'(audio_valid), 32'd1);
            chk("second_sample", 32'(audio_out), 32'(second));
            m_valids++;
            m_addr = next_addr(m_addr, rev);
        end
        step();
        chk("tick_missed", 32'(tick_missed), 32'(m_missed));
    endtask

    task automatic do_restart_idle(input bit rev);
        reverse = rev;
        restart = 1'b1;
        sample_tick = 1'b1;
        play = 1'b1;
        step();
        restart = 1'b0;
        sample_tick = 1'b0;
        chk("restart_idle_no_read", 32'(flash_mem_read), 32'd0);
        m_addr = rev ? END_A : START_A;
        step();
        chk("restart_idle_no_valid", 32'(audio_valid), 32'd0);
    endtask

    // Interrupt a fetch in WAIT_DATA with restart (use_reset=0) or reset (use_reset=1).
    task automatic do_interrupt(input bit rev, input bit use_reset);
        bit acc;
        bit bad;
        reverse = rev;
        play = 1'b1;
        stall_cfg = int'($urandom_range(0, 3));
        pulse_tick();
        m_reads++;
        acc = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!flash_mem_read) begin
                acc = 1'b1;
                break;
            end
            step();
        end
        chk("intr_accepted", 32'(acc), 32'd1);
        if (use_reset) reset = 1'b1;
        else restart = 1'b1;
        step();
        reset = 1'b0;
        restart = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (audio_valid || flash_mem_read) bad = 1'b1;
            step();
        end
        chk("intr_no_valid", 32'(bad), 32'd0);
        if (use_reset) begin
            m_addr = START_A;
            m_missed = 1'b0;
            chk("intr_reset_out", 32'(audio_out), 32'h0);
        end else begin
            m_addr = rev ? END_A : START_A;
        end
        chk("intr_missed", 32'(tick_missed), 32'(m_missed));
    endtask

    initial begin
        int op;
        reset = 1'b1;
        step();
        step();
        chk("rst_read", 32'(flash_mem_read), 32'd0);
        chk("rst_audio", 32'(audio_out), 32'h0);
        chk("rst_valid", 32'(audio_valid), 32'd0);
        chk("rst_missed", 32'(tick_missed), 32'd0);
        chk("rst_addr", 32'(flash_mem_address), 32'h0);
        reset = 1'b0;
        step();

        do_word(1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("addr_after_first", 32'(m_addr), 32'h1);
        do_word(1'b0, 5, 1'b0, 1'b0, 1'b0);
        do_restart_idle(1'b1);
        do_word(1'b1, 1, 1'b0, 1'b0, 1'b0);
        chk("rev_wrap_model", 32'(m_addr), 32'h07FFFE);
        do_restart_idle(1'b1);
        do_word(1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("fwd_wrap_model", 32'(m_addr), 32'h0);
        do_word(1'b0, 2, 1'b0, 1'b1, 1'b0);
        do_word(1'b0, 1, 1'b1, 1'b0, 1'b0);
        do_interrupt(1'b1, 1'b0);
        do_word(1'b1, 0, 1'b0, 1'b0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0: do_restart_idle(1'($urandom_range(0, 1)));
                1: do_interrupt(1'($urandom_range(0, 1)), 1'b0);
                2: do_interrupt(1'($urandom_range(0, 1)), 1'b1);
                3: do_word(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1'b0, 1'b0, 1'b1);
                4: do_word(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1'b0, 1'b1, 1'b0);
                5: do_word(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1'b1, 1'b0, 1'b0);
                default: do_word(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1'b0, 1'b0, 1'b0);
            endcase
        end

        step();
        step();
        chk("total_valids", 32'(valid_cnt), 32'(m_valids));
        chk("total_reads", 32'(n_accepts), 32'(m_reads));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_sample_reader.md
FLASH_SAMPLE_READER -- requirements
Module: flash_sample_reader

Interface
REQ-001 The block SHALL have parameter START_ADDR, default 23'h000000, first word address of the sample region.
REQ-002 The block SHALL have parameter END_ADDR, default 23'h07FFFF, last word address of the sample region (END_ADDR > START_ADDR).
REQ-003 The block SHALL have these ports:
- CLK_50M  input  1  sole clock, all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- play  input  1  1 = run, 0 = pause; level, already synchronous to CLK_50M.
- reverse  input  1  1 = backward playback, 0 = forward; level, already synchronous to CLK_50M.
- sample_tick  input  1  one-cycle pulse at the audio sample rate.
- restart  input  1  one-cycle pulse; jump to start of the region for the current direction.
- flash_mem_read  output  1  read request.
- flash_mem_address  output  23  word address.
- flash_mem_waitrequest  input  1  slave stall.
- flash_mem_readdata  input  32  read word.
- flash_mem_readdatavalid  input  1  readdata qualifier.
- audio_out  output  16  current signed sample.
- audio_valid  output  1  one-cycle pulse when audio_out updates.
- tick_missed  output  1  sticky: a tick was dropped while a fetch was outstanding.

Function
REQ-004 The block SHALL implement the states IDLE, REQ, WAIT_DATA and WAIT_TICK.
REQ-005 IDLE: on sample_tick=1 with play=1, the block SHALL go to REQ; ticks with play=0 SHALL be ignored.
REQ-006 REQ: flash_mem_read SHALL be 1 and flash_mem_address SHALL equal the address register, both held stable until a cycle with flash_mem_waitrequest=0, after which the block SHALL go to WAIT_DATA with flash_mem_read=0.
REQ-007 WAIT_DATA: on flash_mem_readdatavalid=1, the block SHALL capture the word and latch reverse into dir_q.
- On the next cycle it SHALL drive audio_out = word[15:0] (dir_q=0) or word[31:16] (dir_q=1), pulse audio_valid, and enter WAIT_TICK.
REQ-008 WAIT_TICK: on sample_tick=1 with play=1, the block SHALL drive the other half of the captured word and pulse audio_valid on the next cycle.
- In the same cycle it SHALL advance the address: +1 if dir_q=0, -1 if dir_q=1.
- It SHALL then return to IDLE.
- With play=0 it SHALL stay in WAIT_TICK and ignore ticks.
REQ-009 Address wrap SHALL be: forward END_ADDR -> START_ADDR; reverse START_ADDR -> END_ADDR.
REQ-010 Each accepted tick SHALL produce exactly one audio_valid pulse; at most one flash read SHALL be outstanding.
REQ-011 A sample_tick arriving in REQ or WAIT_DATA SHALL be dropped and SHALL set tick_missed=1, which stays 1 until reset.
REQ-012 restart in IDLE or WAIT_TICK SHALL, on the next cycle:
- load the address with START_ADDR (reverse=0) or END_ADDR (reverse=1);
- enter IDLE;
- produce no audio_valid.
REQ-013 restart in REQ or WAIT_DATA SHALL be held pending. The read SHALL complete normally, the returned word SHALL be discarded (no audio_valid), and then the REQ-012 address load SHALL apply.
REQ-014 restart and sample_tick in the same cycle SHALL be resolved as restart, with the tick ignored.
REQ-015 A change of reverse SHALL take effect at the next word capture; the word in progress SHALL complete in dir_q order.

Reset
REQ-016 When reset=1 at a clock edge, the block SHALL enter IDLE with:
- address = START_ADDR, dir_q = 0, restart pending = 0;
- flash_mem_read = 0, audio_out = 16'h0000, audio_valid = 0, tick_missed = 0.
REQ-017 Reset SHALL take priority over all inputs. Reset mid-transaction SHALL abandon the read, and any later readdatavalid SHALL be ignored while in IDLE.

Configuration
REQ-018 With macro PAUSE_MUTE_EN defined, audio_out SHALL read 16'h0000 in every cycle where play=0, and SHALL restore the last sample when play returns to 1.
REQ-019 Without PAUSE_MUTE_EN, audio_out SHALL hold the last output sample while paused.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset, play=1, reverse=0, word 0x1234ABCD at addr 0 -> read at 0x000000, audio_out 0xABCD then 0x1234 on consecutive ticks, address becomes 0x000001.
- Reverse at END_ADDR 0x07FFFF with word 0x1111_2222 -> samples 0x1111 then 0x2222, next address 0x07FFFE; forward at 0x07FFFF -> next address 0x000000.
- waitrequest held for 5 cycles -> read and address stable all 5 cycles, exactly one read accepted.
- Tick during WAIT_DATA -> no extra audio_valid, tick_missed=1 until reset.
- restart during WAIT_DATA, reverse=1 -> word discarded with no audio_valid, next read at 0x07FFFF.
- play=0 in WAIT_TICK for 10 ticks -> no audio_valid, no reads; audio_out=0 with PAUSE_MUTE_EN, last sample without it.
